// File: rtl/tk1_sec_mon_pkg.sv
// Shared constants for the tk1 security monitor: register map, bit positions,
// violation type codes and identification words.
package tk1_sec_mon_pkg;

  localparam logic [7:0] ADDR_NAME0       = 8'h00;
  localparam logic [7:0] ADDR_NAME1       = 8'h01;
  localparam logic [7:0] ADDR_VERSION     = 8'h02;
  localparam logic [7:0] ADDR_CTRL        = 8'h08;
  localparam logic [7:0] ADDR_STATUS      = 8'h09;
  localparam logic [7:0] ADDR_VIOL_ADDR   = 8'h0a;
  localparam logic [7:0] ADDR_VIOL_INFO   = 8'h0b;
  localparam logic [7:0] ADDR_CLEAR       = 8'h0c;
  localparam logic [7:0] ADDR_LOG_DATA    = 8'h0d;
  localparam logic [7:0] ADDR_LOG_LEVEL   = 8'h0e;
  localparam logic [2:0] REGION_PAGE      = 3'b001;

  localparam logic [31:0] CORE_NAME0   = 32'h746B3120;
  localparam logic [31:0] CORE_NAME1   = 32'h73656D6E;
  localparam logic [31:0] CORE_VERSION = 32'h00000001;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_LOCK_BIT   = 1;
  localparam int unsigned PERM_X_DENY_BIT = 0;
  localparam int unsigned PERM_W_DENY_BIT = 1;

  typedef enum logic [1:0] {
    VIOL_RAM       = 2'd0,
    VIOL_FW_EXEC   = 2'd1,
    VIOL_REG_EXEC  = 2'd2,
    VIOL_REG_WRITE = 2'd3
  } viol_type_e;

endpackage

// File: rtl/tk1_sec_mon_if.sv
// CPU access snoop and register bus for tk1_sec_mon.
interface tk1_sec_mon_if;
  logic        cpu_valid;
  logic        cpu_instr;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output cpu_valid, cpu_instr, cpu_we, cpu_addr, cs, we, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  cpu_valid, cpu_instr, cpu_we, cpu_addr, cs, we, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/tk1_sec_mon_fifo.sv
// Synchronous FIFO for the violation address log (DEPTH must be a power of two >= 2).
module tk1_sec_mon_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_c,
  output logic                         empty_c,
  output logic                         drop_c,
  output logic [$clog2(DEPTH):0]       level
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_c, push_ok_c, pop_ok_c;

  assign empty_c   = (cnt_q == '0);
  assign full_c    = (cnt_q == CW'(DEPTH));
  assign pop_ok_c  = pop && !empty_c;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push_ok_c = push && (!full_c || pop_ok_c);
  assign drop_c    = push && !push_ok_c;
  assign head_c    = mem_q[rptr_q];
  assign level     = cnt_q;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok_c) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop_ok_c) rptr_d = rptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push_ok_c) - CW'(pop_ok_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/tk1_sec_mon.sv
// tk1 security monitor: region/FW-RAM/RAM-range access checks, sticky trap, LED blinker.
// Optional violation address log enabled by defining SEC_MON_LOG_EN.
module tk1_sec_mon
  import tk1_sec_mon_pkg::*;
#(
  parameter int unsigned NUM_REGIONS     = 4,
  parameter logic [31:0] FW_RAM_FIRST    = 32'hd0000000,
  parameter logic [31:0] FW_RAM_LAST     = 32'hd00007ff,
  parameter int unsigned RAM_ADDR_BITS   = 17,
  parameter int unsigned BLINK_CTR_WIDTH = 24,
  parameter int unsigned LOG_DEPTH       = 4
) (
  input  logic             clk,
  input  logic             reset,
  tk1_sec_mon_if.slave     bus,
  output logic             force_trap,
  input  logic [2:0]       led_in,
  output logic [2:0]       led_pwm
);
  localparam int unsigned LVL_W = $clog2(LOG_DEPTH) + 1;

  logic                       en_q, en_d, lock_q, lock_d;
  logic [31:0]                first_q [NUM_REGIONS];
  logic [31:0]                first_d [NUM_REGIONS];
  logic [31:0]                last_q  [NUM_REGIONS];
  logic [31:0]                last_d  [NUM_REGIONS];
  logic [1:0]                 perm_q  [NUM_REGIONS];
  logic [1:0]                 perm_d  [NUM_REGIONS];
  logic                       trap_q, trap_d, viol_valid_q, viol_valid_d;
  logic [7:0]                 viol_cnt_q, viol_cnt_d;
  logic [31:0]                viol_addr_q, viol_addr_d;
  logic [2:0]                 viol_region_q, viol_region_d;
  viol_type_e                 viol_type_q, viol_type_d;
  logic                       log_ovf_q, log_ovf_d;
  logic [BLINK_CTR_WIDTH-1:0] blink_ctr_q, blink_ctr_d;
  logic [2:0]                 blink_reg_q, blink_reg_d;

  logic                       reg_wr_c, reg_rd_c, region_sel_c, clear_c;
  logic [2:0]                 reg_idx_c;
  logic [1:0]                 reg_fld_c;
  logic                       viol_c, x_any_c, w_any_c, hit_c;
  logic [2:0]                 x_idx_c, w_idx_c, viol_region_c;
  viol_type_e                 viol_type_c;
  logic [31:0]                log_head;
  logic [LVL_W-1:0]           log_level;
  logic                       log_drop_c;

  assign reg_wr_c     = bus.cs && bus.we;
  assign reg_rd_c     = bus.cs && !bus.we;
  assign region_sel_c = (bus.address[7:5] == REGION_PAGE);
  assign reg_idx_c    = bus.address[4:2];
  assign reg_fld_c    = bus.address[1:0];
  assign clear_c      = reg_wr_c && (bus.address == ADDR_CLEAR) && !trap_q;

`ifdef SEC_MON_LOG_EN
  logic log_pop_c, log_empty_c;
  assign log_pop_c = reg_rd_c && (bus.address == ADDR_LOG_DATA) && !log_empty_c;

  tk1_sec_mon_fifo #(.WIDTH(32), .DEPTH(LOG_DEPTH)) u_log (
    .clk     (clk),
    .reset   (reset),
    .push    (viol_c),
    .din     (bus.cpu_addr),
    .pop     (log_pop_c),
    .head_c  (log_head),
    .empty_c (log_empty_c),
    .drop_c  (log_drop_c),
    .level   (log_level)
  );
`else
  assign log_head   = '0;
  assign log_level  = '0;
  assign log_drop_c = 1'b0;
`endif

  // Access checks; lowest type code, then lowest region index, wins.
  always_comb begin
    x_any_c = 1'b0;
    w_any_c = 1'b0;
    x_idx_c = '0;
    w_idx_c = '0;
    hit_c   = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      hit_c = (bus.cpu_addr >= first_q[i]) && (bus.cpu_addr <= last_q[i]);
      if (!x_any_c && hit_c && perm_q[i][PERM_X_DENY_BIT]) begin
        x_any_c = 1'b1;
        x_idx_c = 3'(i);
      end
      if (!w_any_c && hit_c && perm_q[i][PERM_W_DENY_BIT]) begin
        w_any_c = 1'b1;
        w_idx_c = 3'(i);
      end
    end
    viol_c        = 1'b0;
    viol_type_c   = VIOL_RAM;
    viol_region_c = '0;
    if (bus.cpu_valid) begin
      if ((bus.cpu_addr[31:30] == 2'b01) && (bus.cpu_addr[29:RAM_ADDR_BITS] != '0)) begin
        viol_c = 1'b1;
      end else if (bus.cpu_instr && (bus.cpu_addr >= FW_RAM_FIRST) &&
                   (bus.cpu_addr <= FW_RAM_LAST)) begin
        viol_c      = 1'b1;
        viol_type_c = VIOL_FW_EXEC;
      end else if (en_q && bus.cpu_instr && x_any_c) begin
        viol_c        = 1'b1;
        viol_type_c   = VIOL_REG_EXEC;
        viol_region_c = x_idx_c;
      end else if (en_q && bus.cpu_we && w_any_c) begin
        viol_c        = 1'b1;
        viol_type_c   = VIOL_REG_WRITE;
        viol_region_c = w_idx_c;
      end
    end
  end

  always_comb begin
    en_d          = en_q;
    lock_d        = lock_q;
    first_d       = first_q;
    last_d        = last_q;
    perm_d        = perm_q;
    trap_d        = trap_q;
    viol_valid_d  = viol_valid_q;
    viol_cnt_d    = viol_cnt_q;
    viol_addr_d   = viol_addr_q;
    viol_region_d = viol_region_q;
    viol_type_d   = viol_type_q;
    log_ovf_d     = log_ovf_q;
    blink_ctr_d   = blink_ctr_q + BLINK_CTR_WIDTH'(1);
    blink_reg_d   = blink_reg_q;
    if (blink_ctr_q == '0) blink_reg_d[2] = ~blink_reg_q[2];

    if (reg_wr_c && (bus.address == ADDR_CTRL)) begin
      en_d   = en_q | bus.write_data[CTRL_EN_BIT];
      lock_d = lock_q | bus.write_data[CTRL_LOCK_BIT];
    end
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (reg_wr_c && region_sel_c && !lock_q && (int'(reg_idx_c) == i)) begin
        case (reg_fld_c)
          2'd0:    first_d[i] = bus.write_data;
          2'd1:    last_d[i]  = bus.write_data;
          2'd2:    perm_d[i]  = bus.write_data[1:0];
          default: ;
        endcase
      end
    end

    if (clear_c) begin
      viol_valid_d = 1'b0;
      viol_cnt_d   = '0;
      log_ovf_d    = 1'b0;
    end
    if (log_drop_c) log_ovf_d = 1'b1;
    // Evaluated after CLEAR so a same-cycle violation restarts the count and capture.
    if (viol_c) begin
      trap_d     = 1'b1;
      viol_cnt_d = (viol_cnt_d == 8'hff) ? 8'hff : viol_cnt_d + 8'd1;
      if (!viol_valid_d) begin
        viol_valid_d  = 1'b1;
        viol_addr_d   = bus.cpu_addr;
        viol_region_d = viol_region_c;
        viol_type_d   = viol_type_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q          <= 1'b0;
      lock_q        <= 1'b0;
      first_q       <= '{default: '0};
      last_q        <= '{default: '0};
      perm_q        <= '{default: '0};
      trap_q        <= 1'b0;
      viol_valid_q  <= 1'b0;
      viol_cnt_q    <= '0;
      viol_addr_q   <= '0;
      viol_region_q <= '0;
      viol_type_q   <= VIOL_RAM;
      log_ovf_q     <= 1'b0;
      blink_ctr_q   <= '0;
      blink_reg_q   <= '0;
    end else begin
      en_q          <= en_d;
      lock_q        <= lock_d;
      first_q       <= first_d;
      last_q        <= last_d;
      perm_q        <= perm_d;
      trap_q        <= trap_d;
      viol_valid_q  <= viol_valid_d;
      viol_cnt_q    <= viol_cnt_d;
      viol_addr_q   <= viol_addr_d;
      viol_region_q <= viol_region_d;
      viol_type_q   <= viol_type_d;
      log_ovf_q     <= log_ovf_d;
      blink_ctr_q   <= blink_ctr_d;
      blink_reg_q   <= blink_reg_d;
    end
  end

  // Register read mux; same-cycle combinational data.
  always_comb begin
    bus.read_data = '0;
    if (reg_rd_c) begin
      case (bus.address)
        ADDR_NAME0:     bus.read_data = CORE_NAME0;
        ADDR_NAME1:     bus.read_data = CORE_NAME1;
        ADDR_VERSION:   bus.read_data = CORE_VERSION;
        ADDR_CTRL:      bus.read_data = {30'b0, lock_q, en_q};
        ADDR_STATUS:    bus.read_data = {16'b0, viol_cnt_q, 5'b0, log_ovf_q, viol_valid_q, trap_q};
        ADDR_VIOL_ADDR: bus.read_data = viol_addr_q;
        ADDR_VIOL_INFO: bus.read_data = {26'b0, viol_type_q, 1'b0, viol_region_q};
        ADDR_LOG_DATA:  bus.read_data = log_head;
        ADDR_LOG_LEVEL: bus.read_data = 32'(log_level);
        default:        bus.read_data = '0;
      endcase
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (region_sel_c && (int'(reg_idx_c) == i)) begin
          case (reg_fld_c)
            2'd0:    bus.read_data = first_q[i];
            2'd1:    bus.read_data = last_q[i];
            2'd2:    bus.read_data = {30'b0, perm_q[i]};
            default: bus.read_data = '0;
          endcase
        end
      end
    end
  end

  assign bus.ready  = bus.cs;
  assign force_trap = trap_q;
  assign led_pwm    = trap_q ? blink_reg_q : led_in;
endmodule
